dl_skid_buf: RTL and testbench



---
 rtl/dl_skid_buf.sv | 99 +++++++++
 tb/tb_dl_skid_buf.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dl_skid_buf.sv
// Two-entry skid buffer: registered valid/ready on both sides, full throughput,
// strict FIFO order. out_data is driven straight from the main register.
module dl_skid_buf #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data,
  output logic [1:0]          count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [NUM_BITS-1:0] main_q, skid_q;
  logic                push, pop;
  logic                main_ld_in, main_ld_skid, skid_ld;

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_q;

  always_comb begin
    state_nx     = state;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          main_ld_in = 1'b1;
          state_nx   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          main_ld_in = 1'b1;
        end else if (push) begin
          skid_ld  = 1'b1;
          state_nx = FULL;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_ld_skid = 1'b1;
          state_nx     = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // Flush wins over any handshake; data registers may keep stale contents.
    if (flush) begin
      state_nx     = EMPTY;
      main_ld_in   = 1'b0;
      main_ld_skid = 1'b0;
      skid_ld      = 1'b0;
    end
  end

  // Handshake outputs are flopped from the next state so neither side sees a
  // combinational path from the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= 2'd0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx != EMPTY);
      in_ready  <= (state_nx != FULL);
      count     <= (state_nx == FULL) ? 2'd2 : (state_nx == ONE) ? 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld_in)        main_q <= in_data;
      else if (main_ld_skid) main_q <= skid_q;
      if (skid_ld)           skid_q <= in_data;
    end
  end

endmodule

// File: tb/tb_dl_skid_buf.sv
// Bench for dl_skid_buf: directed scenarios plus randomized handshakes checked
// against a queue-based FIFO model of capacity two.
module tb_dl_skid_buf;

  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_data;
  logic [1:0]    count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [NB-1:0] model_q[$];

  dl_skid_buf #(.NUM_BITS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".count"},     {30'd0, count},     model_q.size());
    check({tag, ".out_valid"}, {31'd0, out_valid}, (model_q.size() > 0) ? 1 : 0);
    check({tag, ".in_ready"},  {31'd0, in_ready},  (model_q.size() < 2) ? 1 : 0);
    if (model_q.size() > 0) check({tag, ".out_data"}, out_data, model_q[0]);
  endtask

  // Called at a falling edge: check state, drive inputs, confirm that the
  // handshake outputs do not react to the new inputs, then take one edge.
  task automatic step(input string tag, input logic iv, input logic [NB-1:0] d,
                      input logic ordy, input logic fl);
    logic exp_ir, exp_ov, do_push, do_pop;
    check_outputs(tag);
    exp_ir    = (model_q.size() < 2);
    exp_ov    = (model_q.size() > 0);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check({tag, ".ir_stable"}, {31'd0, in_ready},  {31'd0, exp_ir});
    check({tag, ".ov_stable"}, {31'd0, out_valid}, {31'd0, exp_ov});
    do_push = iv & exp_ir;
    do_pop  = exp_ov & ordy;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    logic          hold_v;
    logic [NB-1:0] hold_d;
    logic          iv, ordy, fl;
    logic [NB-1:0] d;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then a single push
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.in_ready",  {31'd0, in_ready},  32'd1);
    check("reset.count",     {30'd0, count},     32'd0);
    step("t1", 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    check("t1.first_data", out_data, 32'hA5A5A5A5);
    step("t1", 1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming with out_ready high
    for (int i = 1; i <= 16; i++) step("t2", 1'b1, i, 1'b1, 1'b0);
    step("t2", 1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure and refused input
    step("t3", 1'b1, 32'h11, 1'b0, 1'b0);
    step("t3", 1'b1, 32'h22, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("t3", 1'b1, 32'h33, 1'b0, 1'b0);
    check("t3.full_head", out_data, 32'h11);
    step("t3", 1'b1, 32'h33, 1'b1, 1'b0);
    step("t3", 1'b1, 32'h33, 1'b1, 1'b0);
    step("t3", 1'b0, 32'h0, 1'b1, 1'b0);
    step("t3", 1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while full drops the input presented that cycle
    step("t4", 1'b1, 32'h11, 1'b0, 1'b0);
    step("t4", 1'b1, 32'h22, 1'b0, 1'b0);
    step("t4", 1'b1, 32'h44, 1'b0, 1'b1);
    check("t4.flush_count", {30'd0, count}, 32'd0);
    step("t4", 1'b0, 32'h0, 1'b1, 1'b0);
    step("t4", 1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges while full
    step("t5", 1'b1, 32'h55, 1'b0, 1'b0);
    step("t5", 1'b1, 32'h66, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5.async_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5.async_in_ready",  {31'd0, in_ready},  32'd1);
    check("t5.async_count",     {30'd0, count},     32'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step("t5", 1'b1, 32'h77, 1'b1, 1'b0);
    check("t5.first_after_reset", out_data, 32'h77);

    // Randomized handshakes; a refused input is held stable until accepted
    hold_v = 1'b0;
    hold_d = '0;
    for (int i = 0; i < 10000; i++) begin
      fl = ($urandom_range(63) == 0);
      if (hold_v) begin
        iv = 1'b1;
        d  = hold_d;
      end else begin
        iv = ($urandom_range(3) != 0);
        d  = $urandom;
      end
      ordy   = $urandom_range(1);
      hold_v = iv && (model_q.size() == 2) && !fl;
      hold_d = d;
      step("rand", iv, d, ordy, fl);
    end
    check_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
